// File: rtl/cast_narrow_pipe.sv
// Multi-lane width-narrowing stage with selectable truncate, saturate or scale conversion,
// per-lane clip flags and saturating clip counters, buffered behind a valid/ready FIFO.
module cast_narrow_pipe #(
  parameter int NCH   = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic [NCH-1:0]       out_clip,
  input  logic                 clr_cnt,
  output logic [NCH*CNT_W-1:0] clip_cnt
);

  localparam int D  = IN_W - OUT_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = NCH * OUT_W + NCH;

  // Each conversion returns {clip, y}.
  function automatic logic [OUT_W:0] sat_u(input logic [IN_W-1:0] x);
    if (|x[IN_W-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, x[OUT_W-1:0]};
  endfunction

  // In range iff every bit from the output sign bit upward equals the input sign.
  function automatic logic [OUT_W:0] sat_s(input logic signed [IN_W-1:0] x);
    logic [D:0] top;
    top = x[IN_W-1:OUT_W-1];
    if (top == '0 || top == '1) return {1'b0, x[OUT_W-1:0]};
    if (x < 0) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  function automatic logic [OUT_W:0] conv_f(input logic [1:0] m, input logic [IN_W-1:0] x);
    case (m)
      2'd0:    return {|x[IN_W-1:OUT_W], x[OUT_W-1:0]};
      2'd1:    return sat_u(x);
      2'd2:    return sat_s(signed'(x));
      default: return {1'b0, x[IN_W-1:D]};
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [NCH*OUT_W-1:0] data_p0;
  logic [NCH-1:0]       clip_p0;
  logic                 push;
  logic                 pop;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [EW-1:0]        mem [DEPTH];
  logic [EW-1:0]        head_p1;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Stage p0: combinational per-lane conversion and clip-count update on push
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    typedef logic [IN_W-1:0] lane_t;
    lane_t            x;
    logic [OUT_W:0]   r;
    logic [CNT_W-1:0] cnt;

    assign x = in_data[k*IN_W +: IN_W];
    assign r = conv_f(mode, x);
    assign data_p0[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
    assign clip_p0[k] = r[OUT_W];
    assign clip_cnt[k*CNT_W +: CNT_W] = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            cnt <= '0;
      else if (clr_cnt)                      cnt <= '0;
      else if (push && r[OUT_W] && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  // Stage p1: FIFO of {data, clip}; storage itself is not reset, the count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {data_p0, clip_p0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head_p1  = mem[rd_ptr];
  assign out_data = out_valid ? head_p1[EW-1:NCH] : '0;
  assign out_clip = out_valid ? head_p1[NCH-1:0]  : '0;

endmodule

// File: tb/tb_cast_narrow_pipe.sv
// Directed bench for cast_narrow_pipe (NCH=4, IN_W=8, OUT_W=4, DEPTH=2, CNT_W=2)
// with a queue scoreboard of expected {data, clip} per accepted beat.
module tb_cast_narrow_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_clip;
  logic        clr_cnt;
  logic [7:0]  clip_cnt;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb_q[$];
  logic [19:0] cur_exp;

  always #5 clk = ~clk;

  cast_narrow_pipe #(.NCH(4), .IN_W(8), .OUT_W(4), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_clip(out_clip), .clr_cnt(clr_cnt), .clip_cnt(clip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge score any pop and record any push, then step past the rising edge.
  task automatic tick();
    logic [19:0] head;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", {12'h0, out_data, out_clip}, 32'hFFFF_FFFF);
      end else begin
        head = sb_q.pop_front();
        chk("beat", {12'h0, out_data, out_clip}, {12'h0, head});
      end
    end
    if (in_valid && in_ready) sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] d, input logic [15:0] ed, input logic [3:0] ec);
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    cur_exp  = {ed, ec};
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_out_clip", {28'h0, out_clip}, 32'h0);
    chk("rst_clip_cnt", {24'h0, clip_cnt}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst_n = 1'b1;
    tick();

    // Conversion modes, streaming with out_ready high
    drive(2'd0, 32'h10FF_05A5, 16'h0F55, 4'b1101);
    tick();
    chk("m0_latency", {31'h0, out_valid}, 32'h1);
    chk("m0_cnt", {24'h0, clip_cnt}, 32'h51);
    drive(2'd1, 32'h0010_0FA5, 16'h0FFF, 4'b0101);
    tick();
    chk("m1_cnt", {24'h0, clip_cnt}, 32'h62);
    drive(2'd2, 32'h7FFE_03A5, 16'h7E38, 4'b1001);
    tick();
    chk("m2_cnt", {24'h0, clip_cnt}, 32'hA3);
    drive(2'd3, 32'hFF42_5AA5, 16'hF45A, 4'b0000);
    tick();
    chk("m3_cnt", {24'h0, clip_cnt}, 32'hA3);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("drain1_empty", {31'h0, out_valid}, 32'h0);
    chk("drain1_q", sb_q.size(), 32'h0);

    // Backpressure: two beats fill the buffer, the third waits
    out_ready = 1'b0;
    drive(2'd0, 32'h4433_2211, 16'h4321, 4'hF);
    tick();
    chk("bp_ready_after1", {31'h0, in_ready}, 32'h1);
    drive(2'd0, 32'h8877_6655, 16'h8765, 4'hF);
    tick();
    chk("bp_ready_after2", {31'h0, in_ready}, 32'h0);
    drive(2'd0, 32'h0C0B_0A09, 16'hCBA9, 4'h0);
    tick();
    chk("bp_stall_data_a", {16'h0, out_data}, 32'h4321);
    tick();
    chk("bp_stall_data_b", {16'h0, out_data}, 32'h4321);
    chk("bp_stall_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_stall_q", sb_q.size(), 32'h2);
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_drained_q", sb_q.size(), 32'h0);

    // Counter clear and saturation
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt", {24'h0, clip_cnt}, 32'h0);
    drive(2'd0, 32'h0000_00F0, 16'h0000, 4'b0001);
    repeat (5) tick();
    chk("sat_cnt", {24'h0, clip_cnt}, 32'h03);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    in_valid = 1'b0;
    chk("clr_wins", {24'h0, clip_cnt}, 32'h0);
    repeat (3) tick();
    chk("drain2_q", sb_q.size(), 32'h0);

    // Reset with two beats buffered
    out_ready = 1'b0;
    drive(2'd0, 32'h0000_00F0, 16'h0000, 4'b0001);
    repeat (2) tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("pre_rst_ready", {31'h0, in_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_cnt", {24'h0, clip_cnt}, 32'h0);
    chk("rst_mid_ready", {31'h0, in_ready}, 32'h1);
    sb_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", {31'h0, out_valid}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cast_narrow_pipe.md
Name: cast_narrow_pipe

Overview:
- Multi-channel, parametrised width-narrowing datapath stage with selectable conversion mode.
- Generalises the fixed-width truncating size cast: the narrow type stays the default, and saturating and arithmetic-shift modes are added.
- Adds per-channel clip detection and saturating clip counters behind a valid/ready buffered interface.
- Used as a synthesis/formal regression block for parametrised typedef scoping and width casts inside generate loops.

Parameters:
- NCH, 4: number of independent lanes.
- IN_W, 8: input lane width; must be greater than OUT_W.
- OUT_W, 4: output lane width.
- DEPTH, 2: output buffer entries, 1..16.
- CNT_W, 8: width of each clip counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  conversion mode; sampled with each accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  NCH*IN_W  lane k at bits [k*IN_W +: IN_W].
- out_valid  out  1  head of buffer valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  NCH*OUT_W  lane k at bits [k*OUT_W +: OUT_W].
- out_clip  out  NCH  per-lane clip flag travelling with out_data.
- clr_cnt  in  1  synchronous clear of all clip counters.
- clip_cnt  out  NCH*CNT_W  per-lane saturating clip counts.

Behaviour:
- Reset (async assert, sync release): buffer empty, out_valid=0, out_data=0, out_clip=0, clip_cnt=0, in_ready=1.
- Conversion is per lane and combinational on in_data and mode. Results are written into the buffer on acceptance. Let x be the IN_W-bit lane value and D=IN_W-OUT_W.
- Mode 0, truncate: y=x[OUT_W-1:0]. clip=1 iff x[IN_W-1:OUT_W] is nonzero.
- Mode 1, unsigned saturate: y=x if x<2^OUT_W, else all-ones. clip=1 iff clamped.
- Mode 2, signed saturate: x and y are two's complement. y=x if x is in [-2^(OUT_W-1), 2^(OUT_W-1)-1]; otherwise y=max or min by the sign of x. clip=1 iff clamped.
- Mode 3, scale: y=x[IN_W-1:D], i.e. arithmetic shift right by D. clip=0 always.
- Buffer: DEPTH-entry FIFO of {out_data,out_clip}.
  - in_ready = (count<DEPTH). It is registered-state only, with no combinational path from out_ready.
  - Push on in_valid&&in_ready; pop on out_valid&&out_ready. Simultaneous push and pop when full is not possible because in_ready=0.
  - Simultaneous push and pop when not full keeps count unchanged.
- Latency: a beat accepted in cycle N appears at out_data in cycle N+1 when the buffer was empty. Otherwise it appears after all earlier beats, in order. The output is held stable while out_valid && !out_ready.
- Read/write pointers wrap modulo DEPTH (non-power-of-2 allowed).
- Clip counters:
  - clip_cnt[k] increments by 1 at each push with clip=1 on lane k.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt sets all counters to 0. When clr_cnt coincides with an increment, the clear wins and the result is 0.
  - Counting happens at push, not pop.
- Reset mid-operation: buffered beats are discarded and out_valid drops immediately (asynchronously). No beat is emitted after release unless a new push occurs.
- Changing mode between beats affects only subsequently accepted beats.

Test Plan:
- Defaults, mode 0, lanes {0xA5,0x05,0xFF,0x10}, out_ready=1 -> next cycle out_data lanes {0x5,0x5,0xF,0x0}, out_clip=4'b1101, clip_cnt lanes {1,0,1,1}.
- Mode 1, lanes {0xA5,0x0F,0x10,0x00} -> {0xF,0xF,0xF,0x0}, out_clip=4'b0101. Mode 2, lanes {0xA5,0x03,0xFE,0x7F} -> {0x8,0x3,0xE,0x7}, out_clip=4'b1001.
- Mode 3, lanes {0xA5,0x5A,0x42,0xFF} -> {0xA,0x5,0x4,0xF}, out_clip=0, counters unchanged.
- Backpressure: out_ready=0 with 3 back-to-back beats -> the first two are accepted, in_ready=0 from the cycle after the second, and the third is held. Raising out_ready -> the three beats emerge in order, and out_data is stable while stalled.
- Counter saturation with CNT_W=2: 5 clipping beats on lane 0 -> clip_cnt[0]=3. clr_cnt in the same cycle as a clipping push -> 0.
- Reset with 2 beats buffered: rst_n low -> out_valid=0 the same cycle, clip_cnt=0, in_ready=1. After release, no spurious output.
